// File: rtl/ssm_step_sched.sv
// Per-token sequencer for the SSM state update: dA/dBx in parallel, state add, C*h output.
// Optional watchdog on every wait state is built when SSM_SCHED_TIMEOUT_EN is defined.
module ssm_step_sched #(
  parameter int unsigned TW     = 8,
  parameter int unsigned TO_CYC = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          abort,
  input  logic [TW-1:0] num_tok,
  output logic          dah_start,
  input  logic          dah_done,
  output logic          dbx_start,
  input  logic          dbx_done,
  output logic          dah_release,
  output logic          hadd_start,
  input  logic          hadd_done,
  output logic          y_start,
  input  logic          y_done,
  output logic          h_bank,
  output logic [TW-1:0] tok_idx,
  output logic          busy,
  output logic          step_done,
  output logic          all_done,
  output logic          err
);

  typedef enum logic [3:0] {
    IDLE, ISSUE_AB, WAIT_AB, RELEASE, ISSUE_ADD, WAIT_ADD, ISSUE_Y, WAIT_Y, STEP, FIN
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] n_tok_q, n_tok_d;
  logic [TW-1:0] tok_d;
  logic          bank_d;
  logic          a_flag_q, a_flag_d;
  logic          b_flag_q, b_flag_d;
  logic          abort_rel_c;
  logic          run_acc_c;
  logic          wd_hit_c;

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    n_tok_d     = n_tok_q;
    tok_d       = tok_idx;
    bank_d      = h_bank;
    a_flag_d    = a_flag_q;
    b_flag_d    = b_flag_q;
    abort_rel_c = 1'b0;
    run_acc_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (run && !abort) begin
          run_acc_c = 1'b1;
          n_tok_d   = num_tok;
          tok_d     = '0;
          bank_d    = 1'b0;
          state_d   = (num_tok != '0) ? ISSUE_AB : FIN;
        end
      end
      ISSUE_AB: begin
        a_flag_d = 1'b0;
        b_flag_d = 1'b0;
        state_d  = WAIT_AB;
      end
      WAIT_AB: begin
        a_flag_d = a_flag_q | dah_done;
        b_flag_d = b_flag_q | dbx_done;
        if (a_flag_d && b_flag_d) state_d = RELEASE;
      end
      RELEASE:   state_d = ISSUE_ADD;
      ISSUE_ADD: state_d = WAIT_ADD;
      WAIT_ADD:  if (hadd_done) state_d = ISSUE_Y;
      ISSUE_Y:   state_d = WAIT_Y;
      WAIT_Y:    if (y_done) state_d = STEP;
      STEP: begin
        bank_d = ~h_bank;
        if (tok_idx == n_tok_q - TW'(1)) begin
          state_d = FIN;
        end else begin
          tok_d   = tok_idx + TW'(1);
          state_d = ISSUE_AB;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort or watchdog: drop to IDLE, freeing a decay unit that already holds done
    if (state_q != IDLE && (abort || wd_hit_c)) begin
      state_d     = IDLE;
      tok_d       = tok_idx;
      bank_d      = h_bank;
      abort_rel_c = (state_q == WAIT_AB) && (a_flag_q || dah_done);
    end
  end

  // State, bookkeeping and registered outputs (decoded from the next state)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      n_tok_q     <= '0;
      tok_idx     <= '0;
      h_bank      <= 1'b0;
      a_flag_q    <= 1'b0;
      b_flag_q    <= 1'b0;
      dah_start   <= 1'b0;
      dbx_start   <= 1'b0;
      dah_release <= 1'b0;
      hadd_start  <= 1'b0;
      y_start     <= 1'b0;
      busy        <= 1'b0;
      step_done   <= 1'b0;
      all_done    <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_tok_q     <= n_tok_d;
      tok_idx     <= tok_d;
      h_bank      <= bank_d;
      a_flag_q    <= a_flag_d;
      b_flag_q    <= b_flag_d;
      dah_start   <= (state_d == ISSUE_AB);
      dbx_start   <= (state_d == ISSUE_AB);
      dah_release <= (state_d == RELEASE) || abort_rel_c;
      hadd_start  <= (state_d == ISSUE_ADD);
      y_start     <= (state_d == ISSUE_Y);
      busy        <= (state_d != IDLE);
      step_done   <= (state_d == STEP);
      all_done    <= (state_d == FIN);
    end
  end

`ifdef SSM_SCHED_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TO_CYC + 1);

  logic [CW-1:0] wd_cnt_q;
  logic          in_wait_c;

  assign in_wait_c = (state_q == WAIT_AB) || (state_q == WAIT_ADD) || (state_q == WAIT_Y);
  assign wd_hit_c  = in_wait_c && (wd_cnt_q == CW'(TO_CYC - 1));

  // Per-wait-state cycle counter; any state change restarts it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_q <= '0;
      err      <= 1'b0;
    end else begin
      if (state_d != state_q)  wd_cnt_q <= '0;
      else if (in_wait_c)      wd_cnt_q <= wd_cnt_q + CW'(1);
      if (run_acc_c)           err <= 1'b0;
      else if (wd_hit_c)       err <= 1'b1;
    end
  end
`else
  logic unused_to;

  assign wd_hit_c  = 1'b0;
  assign err       = 1'b0;
  assign unused_to = ^{run_acc_c, 1'(TO_CYC)};
`endif

endmodule
